sram_arbiter: RTL and testbench
===============================

// Module: sram_arbiter
// PURPOSE
//  Shares the single SRAM port (ram_ctrl read/write/workdone handshake) among three requesters:
//  P0 = VGA/display fetch, P1 = camera frame writer, P2 = UART/host access.
//  P0 has fixed top priority; P1 and P2 alternate round-robin. One transaction is in flight at a time.
//  A watchdog aborts any transaction whose workdone never arrives.
// PARAMETERS
//  ADDR_W   20  SRAM word-address width
//  DATA_W   32  SRAM data width
//  TMO_CYC  15  cycles in WAIT before abort (4-bit counter; legal range 1..15)
// PORTS
//  clk          in   1       system clock
//  rst          in   1       asynchronous reset, active-low
//  req[2:0]     in   3       per-port request level; held until that port's ack
//  we[2:0]      in   3       per-port 1=write, 0=read; sampled at grant
//  addr0/1/2    in   ADDR_W  per-port address; sampled at grant
//  wdata0/1/2   in   DATA_W  per-port write data; sampled at grant
//  ack[2:0]     out  3       one-cycle completion pulse to the granted port
//  err          out  1       high with ack when the transaction timed out
//  rdata        out  DATA_W  read data; valid in the ack cycle, held until next ack
//  mem_read     out  1       to ram_ctrl.read
//  mem_write    out  1       to ram_ctrl.write
//  mem_addr     out  ADDR_W  to ram_ctrl.inp_addr
//  mem_wdata    out  DATA_W  to ram_ctrl.inp_data
//  mem_done     in   1       from ram_ctrl.workdone (level)
//  mem_rdata    in   DATA_W  from ram_ctrl.out_data
//  grant_id     out  2       debug: 0..2 = owner, 3 = idle (drives a dig_ctrl digit)
// BEHAVIOUR
//  Reset:
//   - All outputs 0, except grant_id = 3.
//   - State IDLE; round-robin pointer rr = P1.
//   - Reset asserted mid-transaction drops mem_read/mem_write immediately; no ack is issued.
//  FSM IDLE -> ISSUE -> WAIT -> RELEASE -> IDLE.
//  IDLE:
//   - If any req bit is set, pick the winner:
//     - req[0] wins;
//     - else rr's port if it is requesting;
//     - else the other of P1/P2.
//   - Latch the winner's we/addr/wdata into mem_* registers and set grant_id.
//   - Go to ISSUE.
//  ISSUE:
//   - Assert mem_read = ~we or mem_write = we for the latched port.
//   - Clear the timeout counter; go to WAIT.
//  WAIT:
//   - mem_read/mem_write held; counter increments every cycle.
//   - mem_done = 1: capture mem_rdata into rdata (reads only), pulse ack[owner], err = 0, go to RELEASE.
//   - Counter reaches TMO_CYC without mem_done: pulse ack[owner] with err = 1, rdata unchanged, go to RELEASE.
//  RELEASE:
//   - mem_read/mem_write deasserted; grant_id = 3.
//   - If the owner was P1 or P2, rr = the other of P1/P2; rr is unchanged after a P0 transaction.
//   - Wait until mem_done = 0, then go to IDLE. This guarantees ram_ctrl sees a low gap between commands.
//  Latency: req seen in IDLE -> mem strobe 2 cycles later; ack = cycle after mem_done first seen high.
//  Minimum back-to-back period per transaction = 4 cycles plus ram_ctrl time.
//  Requesters must not drop req before ack. A req drop mid-transaction does not abort it; the ack is still pulsed.
//  Simultaneous req from all three ports: order is P0, rr-port, other port, assuming P0 re-requests each time.
//  P0 may starve P1/P2 by design; the display fetch is bounded by the line rate.
//  mem_read and mem_write are never both high. mem_addr/mem_wdata are stable for the whole strobe.
// STRUCTURE
//  Shared package capiano_pkg:
//   - ARB_IDLE/ISSUE/WAIT/RELEASE state encodings (2 bits);
//   - port indices P_VGA = 0, P_CAM = 1, P_UART = 2;
//   - GRANT_NONE = 3.
//  One sub-module, arb_pick3 (combinational): inputs req[2:0] and rr; outputs winner id and valid.
//  FSM, latches, watchdog and rr update stay in sram_arbiter.
// TESTING
//  1. Single read: req=3'b010, we1=0, addr1=20'h00123; model sets mem_done 3 cycles after mem_read = 1,
//     mem_rdata = 32'hDEADBEEF -> ack = 3'b010 once, rdata = DEADBEEF, err = 0, mem_addr = 00123.
//  2. Contention: req = 3'b111 held; model done latency 2 -> grants P0, P1, P0, P2, P0, P1...
//     Drop req[0] after its first ack -> grants P1, P2, P1, P2.
//  3. Write: P2 we = 1, addr = 20'hFFFFF, wdata = 32'hA5A5A5A5 -> mem_write pulse with those values;
//     mem_read = 0 throughout; ack[2] pulses.
//  4. Timeout: model never raises mem_done -> ack pulses with err = 1 after 15 WAIT cycles;
//     next request proceeds normally.
//  5. Sticky done: model holds mem_done high 5 cycles after completion -> FSM stays in RELEASE,
//     no new strobe until mem_done = 0.
//  6. Reset mid-WAIT: rst = 0 async -> mem_read = 0 the same cycle, no ack, grant_id = 3;
//     after release the rr pointer = P1.

Source files
------------

// File: rtl/capiano_pkg.sv
// Shared encodings for the SRAM port arbiter: FSM states, requester ids and
// the round-robin partner helper.
package capiano_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ISSUE   = 2'd1,
    ARB_WAIT    = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_t;

  localparam logic [1:0] P_VGA      = 2'd0;
  localparam logic [1:0] P_CAM      = 2'd1;
  localparam logic [1:0] P_UART     = 2'd2;
  localparam logic [1:0] GRANT_NONE = 2'd3;

  // The round-robin pair is P_CAM/P_UART; returns the member that is not p.
  function automatic logic [1:0] rr_other(input logic [1:0] p);
    return (p == P_CAM) ? P_UART : P_CAM;
  endfunction

endpackage

// File: rtl/arb_pick3.sv
// Combinational winner selection: P_VGA first, then the round-robin port,
// then its partner.
module arb_pick3
  import capiano_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] rr,
  output logic [1:0] winner,
  output logic       valid
);

  logic [1:0] other;
  logic       rr_req;
  logic       other_req;

  assign other     = rr_other(rr);
  assign rr_req    = (rr == P_UART) ? req[2] : req[1];
  assign other_req = (other == P_UART) ? req[2] : req[1];

  always_comb begin
    winner = P_VGA;
    valid  = 1'b1;
    if (req[0]) begin
      winner = P_VGA;
    end else if (rr_req) begin
      winner = rr;
    end else if (other_req) begin
      winner = other;
    end else begin
      valid = 1'b0;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Three-way arbiter for the single ram_ctrl port: one transaction in flight,
// fixed P_VGA priority, P_CAM/P_UART round-robin, watchdog abort on WAIT.
module sram_arbiter
  import capiano_pkg::*;
#(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 32,
  parameter int TMO_CYC = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        req,
  input  logic [2:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [DATA_W-1:0] wdata2,
  output logic [2:0]        ack,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        grant_id
);

  localparam logic [3:0] TMO_LIM = 4'(TMO_CYC);

  arb_state_t        state_reg, state_next;
  logic [1:0]        owner_reg, owner_next;
  logic [1:0]        rr_reg, rr_next;
  logic              we_reg, we_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic              read_reg, read_next;
  logic              write_reg, write_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic [2:0]        ack_reg, ack_next;
  logic              err_reg, err_next;
  logic [1:0]        gid_reg, gid_next;

  logic [1:0] pick_id;
  logic       pick_valid;

  arb_pick3 u_pick (
    .req    (req),
    .rr     (rr_reg),
    .winner (pick_id),
    .valid  (pick_valid)
  );

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    rr_next    = rr_reg;
    we_next    = we_reg;
    cnt_next   = cnt_reg;
    read_next  = read_reg;
    write_next = write_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;
    ack_next   = 3'b000;
    err_next   = 1'b0;
    gid_next   = gid_reg;

    unique case (state_reg)
      ARB_IDLE: begin
        if (pick_valid) begin
          owner_next = pick_id;
          gid_next   = pick_id;
          state_next = ARB_ISSUE;
          unique case (pick_id)
            P_CAM: begin
              we_next    = we[1];
              addr_next  = addr1;
              wdata_next = wdata1;
            end
            P_UART: begin
              we_next    = we[2];
              addr_next  = addr2;
              wdata_next = wdata2;
            end
            default: begin
              we_next    = we[0];
              addr_next  = addr0;
              wdata_next = wdata0;
            end
          endcase
        end
      end
      ARB_ISSUE: begin
        read_next  = ~we_reg;
        write_next = we_reg;
        cnt_next   = 4'd0;
        state_next = ARB_WAIT;
      end
      ARB_WAIT: begin
        cnt_next = cnt_reg + 4'd1;
        // Completion and watchdog expiry share the same exit; err tells them apart.
        if (mem_done || (cnt_next == TMO_LIM)) begin
          read_next  = 1'b0;
          write_next = 1'b0;
          gid_next   = GRANT_NONE;
          ack_next   = 3'b001 << owner_reg;
          err_next   = ~mem_done;
          if (mem_done && !we_reg) begin
            rdata_next = mem_rdata;
          end
          if (owner_reg != P_VGA) begin
            rr_next = rr_other(owner_reg);
          end
          state_next = ARB_RELEASE;
        end
      end
      ARB_RELEASE: begin
        if (!mem_done) begin
          state_next = ARB_IDLE;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ARB_IDLE;
      owner_reg <= P_VGA;
      rr_reg    <= P_CAM;
      we_reg    <= 1'b0;
      cnt_reg   <= 4'd0;
      read_reg  <= 1'b0;
      write_reg <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      ack_reg   <= 3'b000;
      err_reg   <= 1'b0;
      gid_reg   <= GRANT_NONE;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      rr_reg    <= rr_next;
      we_reg    <= we_next;
      cnt_reg   <= cnt_next;
      read_reg  <= read_next;
      write_reg <= write_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
      ack_reg   <= ack_next;
      err_reg   <= err_next;
      gid_reg   <= gid_next;
    end
  end

  assign ack       = ack_reg;
  assign err       = err_reg;
  assign rdata     = rdata_reg;
  assign mem_read  = read_reg;
  assign mem_write = write_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign grant_id  = gid_reg;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a small ram_ctrl model (configurable
// done latency, sticky done, never-done).
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [2:0]  we;
  logic [19:0] addr0, addr1, addr2;
  logic [31:0] wdata0, wdata1, wdata2;
  logic [2:0]  ack;
  logic        err;
  logic [31:0] rdata;
  logic        mem_read, mem_write;
  logic [19:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_done = 1'b0;
  logic [31:0] mem_rdata;
  logic [1:0]  grant_id;

  sram_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .addr0     (addr0),
    .addr1     (addr1),
    .addr2     (addr2),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .wdata2    (wdata2),
    .ack       (ack),
    .err       (err),
    .rdata     (rdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_done  (mem_done),
    .mem_rdata (mem_rdata),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ram_ctrl model
  int lat_cfg    = 3;
  int sticky_cfg = 0;
  bit never_done = 1'b0;
  int cnt_m      = 0;
  int hold_m     = 0;

  always @(posedge clk) begin
    if (!(mem_read || mem_write)) begin
      cnt_m <= 0;
      if (hold_m > 0) hold_m <= hold_m - 1;
      else            mem_done <= 1'b0;
    end else begin
      cnt_m <= cnt_m + 1;
      if (!never_done && (cnt_m + 1 >= lat_cfg)) begin
        mem_done <= 1'b1;
        hold_m   <= sticky_cfg;
      end
    end
  end

  // strobe monitor: captures each command and counts protocol violations
  int          strobe_start = 0;
  int          done_fall    = 0;
  int          viol         = 0;
  logic [19:0] s_addr;
  logic [31:0] s_wdata;
  logic [1:0]  s_gid;
  logic        s_read, s_write;
  logic        prev_strobe = 1'b0;
  logic        prev_done   = 1'b0;

  always @(negedge clk) begin
    if ((mem_read || mem_write) && !prev_strobe) begin
      strobe_start = cyc;
      s_addr  = mem_addr;
      s_wdata = mem_wdata;
      s_gid   = grant_id;
      s_read  = mem_read;
      s_write = mem_write;
      if (mem_done) viol++;
    end else if ((mem_read || mem_write) && prev_strobe) begin
      if (mem_addr != s_addr || mem_wdata != s_wdata ||
          mem_read != s_read || mem_write != s_write) viol++;
    end
    if (mem_read && mem_write) viol++;
    if (!mem_done && prev_done) done_fall = cyc;
    prev_strobe = mem_read || mem_write;
    prev_done   = mem_done;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(input int budget, output logic [2:0] a);
    bit seen = 1'b0;
    a = 3'b000;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (ack != 3'b000) begin
        a    = ack;
        seen = 1'b1;
        $display("[cyc %0d] ack=%b err=%b rdata=%h", cyc, ack, err, rdata);
      end
    end
    if (!seen) check_val("ack_wait_expired", 1, 0);
  endtask

  task automatic wait_strobe(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (mem_read || mem_write) seen = 1'b1;
    end
    if (!seen) check_val("strobe_wait_expired", 1, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  logic [2:0] a, a1, a2;
  int req_cyc, ack_cyc;
  logic [2:0] seq_a [6];
  logic [2:0] seq_b [5];

  initial begin
    rst = 1'b0; req = 3'b000; we = 3'b000;
    addr0 = '0; addr1 = '0; addr2 = '0;
    wdata0 = '0; wdata1 = '0; wdata2 = '0;
    mem_rdata = '0;
    seq_a = '{3'b001, 3'b010, 3'b001, 3'b100, 3'b001, 3'b010};
    seq_b = '{3'b001, 3'b010, 3'b100, 3'b010, 3'b100};
    repeat (2) @(negedge clk);

    check_val("rst_ack",       ack,       3'b000);
    check_val("rst_err",       err,       1'b0);
    check_val("rst_rdata",     rdata,     32'h0);
    check_val("rst_mem_read",  mem_read,  1'b0);
    check_val("rst_mem_write", mem_write, 1'b0);
    check_val("rst_mem_addr",  mem_addr,  20'h0);
    check_val("rst_mem_wdata", mem_wdata, 32'h0);
    check_val("rst_grant_id",  grant_id,  2'd3);
    rst = 1'b1;
    @(negedge clk);

    // single read from P1
    addr1 = 20'h00123; mem_rdata = 32'hDEADBEEF; lat_cfg = 3;
    req_cyc = cyc;
    req = 3'b010;
    wait_ack(40, a);
    req[1] = 1'b0;
    check_val("rd_ack",        a,     3'b010);
    check_val("rd_err",        err,   1'b0);
    check_val("rd_rdata",      rdata, 32'hDEADBEEF);
    check_val("rd_addr",       s_addr, 20'h00123);
    check_val("rd_is_read",    {s_read, s_write}, 2'b10);
    check_val("rd_gid",        s_gid, 2'd1);
    check_val("rd_req_to_strobe", strobe_start - req_cyc, 2);
    check_val("rd_strobe_to_ack", cyc - strobe_start, 4);
    check_val("rd_gid_release", grant_id, 2'd3);
    @(negedge clk);
    check_val("rd_ack_single_pulse", ack, 3'b000);

    // contention, P0 re-requests only after another port was served
    do_reset();
    mem_rdata = 32'h11112222; lat_cfg = 2;
    req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      wait_ack(40, a);
      check_val($sformatf("rr_a%0d", k), a, seq_a[k]);
      req[0] = a[0] ? 1'b0 : 1'b1;
    end
    req = 3'b000;

    // contention, P0 drops after its first ack
    do_reset();
    req = 3'b111;
    for (int k = 0; k < 5; k++) begin
      wait_ack(40, a);
      check_val($sformatf("rr_b%0d", k), a, seq_b[k]);
      if (a[0]) req[0] = 1'b0;
    end
    req = 3'b000;

    // write from P2; rdata must keep the last read value
    repeat (3) @(negedge clk);
    mem_rdata = 32'h5555AAAA;
    we = 3'b100; addr2 = 20'hFFFFF; wdata2 = 32'hA5A5A5A5;
    req = 3'b100;
    wait_ack(40, a);
    req = 3'b000;
    check_val("wr_ack",      a,       3'b100);
    check_val("wr_err",      err,     1'b0);
    check_val("wr_is_write", {s_read, s_write}, 2'b01);
    check_val("wr_addr",     s_addr,  20'hFFFFF);
    check_val("wr_wdata",    s_wdata, 32'hA5A5A5A5);
    check_val("wr_gid",      s_gid,   2'd2);
    check_val("wr_rdata_held", rdata, 32'h11112222);

    // watchdog timeout, then a normal read
    repeat (3) @(negedge clk);
    we = 3'b000; never_done = 1'b1;
    addr1 = 20'h00456; mem_rdata = 32'h77778888;
    req = 3'b010;
    wait_ack(60, a);
    req = 3'b000;
    check_val("tmo_ack",   a,     3'b010);
    check_val("tmo_err",   err,   1'b1);
    check_val("tmo_rdata_held", rdata, 32'h11112222);
    check_val("tmo_cycles", cyc - strobe_start, 15);
    never_done = 1'b0;
    addr2 = 20'h00789;
    req = 3'b100;
    wait_ack(40, a);
    req = 3'b000;
    check_val("post_tmo_ack",   a,     3'b100);
    check_val("post_tmo_err",   err,   1'b0);
    check_val("post_tmo_rdata", rdata, 32'h77778888);

    // sticky done: next strobe waits for mem_done to fall
    repeat (3) @(negedge clk);
    sticky_cfg = 5;
    req = 3'b010;
    wait_ack(40, a1);
    ack_cyc = cyc;
    sticky_cfg = 0;
    wait_ack(60, a2);
    req = 3'b000;
    check_val("sticky_ack1", a1, 3'b010);
    check_val("sticky_ack2", a2, 3'b010);
    check_val("sticky_gap_after_done", strobe_start - done_fall, 3);
    check_val("sticky_ack_to_strobe",  strobe_start - ack_cyc, 9);

    // reset mid-WAIT
    repeat (3) @(negedge clk);
    never_done = 1'b1;
    req = 3'b100;
    wait_strobe(20);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_val("arst_mem_read", mem_read, 1'b0);
    check_val("arst_grant_id", grant_id, 2'd3);
    @(negedge clk);
    @(negedge clk);
    check_val("arst_no_ack", {ack, err}, 4'b0000);
    never_done = 1'b0;
    req = 3'b110;
    rst = 1'b1;
    wait_ack(40, a);
    req[1] = 1'b0;
    check_val("arst_rr_p1", a, 3'b010);
    wait_ack(40, a);
    req = 3'b000;
    check_val("arst_next_p2", a, 3'b100);

    repeat (4) @(negedge clk);
    check_val("protocol_violations", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
